// File: rtl/lcd_pkg.sv
// Shared geometry and control-character constants for the LCD text path.
// Used by the text buffer and the HD44780 driver so both agree on the
// frame layout (line-major, LINE_WIDTH characters per line).
package lcd_pkg;

  localparam int LINE_WIDTH = 16;                 // must be a power of two
  localparam int LINES      = 4;                  // must be a power of two
  localparam int DEPTH      = LINE_WIDTH * LINES;
  localparam int AW         = $clog2(DEPTH);
  localparam int LW         = $clog2(LINE_WIDTH);

  localparam logic [7:0] FILL_CHAR = 8'h20;

  // Stream control characters
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // First printable code; anything below is control
  localparam logic [7:0] CH_PRINT_MIN = 8'h20;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/lcd_text_ram.sv
// DEPTH x 8 character store: one write port, one registered read port.
// The array itself has no reset so it maps onto block/distributed RAM;
// only the read-data register is cleared by rst.
// Ports:
//   clk, rst      clock, async active-low reset (read register only)
//   we/waddr/wdata write port
//   raddr/rdata   read port, 1-cycle latency, read-before-write
module lcd_text_ram
  import lcd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read/write returns the old byte (NBA ordering).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/lcd_text_buffer.sv
// 4x16 character frame buffer feeding the HD44780 4-bit driver.
// Content arrives via a random-access write port or a cursor-based
// character stream; the driver reads it back through rd_addr/rd_data.
// trg is pulsed when content changed, the driver is idle and the refresh
// holdoff has expired.
// Ports:
//   clk, rst              clock, async active-low reset
//   wr_en/wr_addr/wr_data random-access write (wins over the stream)
//   ch_valid/ch_data/ch_ready  character stream handshake
//   rd_addr/rd_data       driver read port (1-cycle latency)
//   lcd_busy              driver busy flag
//   trg                   single-cycle print request
//   cursor                current stream write position
//   dirty                 content changed since last trg
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter int MIN_REFRESH_CYCLES = 25000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          ch_valid,
  input  logic [7:0]    ch_data,
  output logic          ch_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          lcd_busy,
  output logic          trg,
  output logic [AW-1:0] cursor,
  output logic          dirty
);

  localparam int HW = (MIN_REFRESH_CYCLES > 1) ? $clog2(MIN_REFRESH_CYCLES) : 1;

  state_t        state;
  logic [AW-1:0] fill_idx;
  logic [HW-1:0] holdoff;

  logic          ch_acc;
  logic          ch_print;
  logic          fire;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;

  // Random-access writes steal the RAM port, so the stream stalls then.
  assign ch_ready = (state == IDLE) && !wr_en;
  assign ch_acc   = ch_valid && ch_ready;
  assign ch_print = (ch_data >= CH_PRINT_MIN);

  // Registered trg: !trg keeps it to one cycle even if holdoff is tiny.
  assign fire = (state == IDLE) && dirty && !lcd_busy && !trg && (holdoff == '0);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cursor;
    ram_wdata = ch_data;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = fill_idx;
      ram_wdata = FILL_CHAR;
    end else if (wr_en) begin
      ram_we    = 1'b1;
      ram_waddr = wr_addr;
      ram_wdata = wr_data;
    end else if (ch_acc && ch_print) begin
      ram_we    = 1'b1;
    end
  end

  lcd_text_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      fill_idx <= '0;
      cursor   <= '0;
      dirty    <= 1'b0;
      trg      <= 1'b0;
      holdoff  <= '0;
    end else begin
      trg <= fire;

      if (fire)                 holdoff <= HW'(MIN_REFRESH_CYCLES - 1);
      else if (holdoff != '0)   holdoff <= holdoff - 1'b1;

      case (state)
        CLEAR: begin
          fill_idx <= fill_idx + 1'b1;
          if (fill_idx == AW'(DEPTH - 1)) begin
            state  <= IDLE;
            cursor <= '0;
            dirty  <= 1'b1;
          end
        end

        IDLE: begin
          // A write in the trg cycle must win so it is not lost.
          if (fire) dirty <= 1'b0;

          if (wr_en) begin
            dirty <= 1'b1;
          end else if (ch_acc) begin
            if (ch_print) begin
              cursor <= cursor + 1'b1;
              dirty  <= 1'b1;
            end else begin
              case (ch_data)
                CH_LF: cursor <= {cursor[AW-1:LW] + 1'b1, {LW{1'b0}}};
                CH_CR: cursor[LW-1:0] <= '0;
                CH_BS: if (cursor != '0) cursor <= cursor - 1'b1;
                CH_FF: begin
                  state    <= CLEAR;
                  fill_idx <= '0;
                end
                default: ;
              endcase
            end
          end
        end

        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
module tb_lcd_text_buffer;
  import lcd_pkg::*;

  localparam int M = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          ch_valid = 1'b0;
  logic [7:0]    ch_data = '0;
  logic          ch_ready;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          lcd_busy = 1'b0;
  logic          trg;
  logic [AW-1:0] cursor;
  logic          dirty;

  int checks = 0;
  int errors = 0;

  lcd_text_buffer #(.MIN_REFRESH_CYCLES(M)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .lcd_busy(lcd_busy),
    .trg(trg), .cursor(cursor), .dirty(dirty)
  );

  always #5 clk = ~clk;

  task automatic send_ch(input logic [7:0] c);
    int n;
    @(negedge clk);
    ch_valid = 1'b1;
    ch_data  = c;
    #1;
    n = 0;
    while (!ch_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ch_ready) begin
      checks++; errors++;
      $display("FAIL send_ch timeout: ch_ready=%b required 1", ch_ready);
    end
    @(posedge clk);
    #1 ch_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    int bad;
    #12;
    checks++;
    if ({ch_ready, trg, cursor, dirty, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_values: ready=%b trg=%b cur=%0d dirty=%b rd=%h required all 0",
               ch_ready, trg, cursor, dirty, rd_data);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      if (ch_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_ready_low: %0d cycles with ch_ready=1, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (ch_ready !== 1'b1 || dirty !== 1'b1 || trg !== 1'b0 || cursor !== '0) begin
      errors++;
      $display("FAIL clear_done: ready=%b dirty=%b trg=%b cur=%0d required 1 1 0 0",
               ch_ready, dirty, trg, cursor);
    end
    @(negedge clk);
    checks++;
    if (trg !== 1'b1 || dirty !== 1'b0) begin
      errors++;
      $display("FAIL first_trg: trg=%b dirty=%b required 1 0", trg, dirty);
    end
    @(negedge clk);
    checks++;
    if (trg !== 1'b0) begin
      errors++;
      $display("FAIL trg_single: trg=%b required 0", trg);
    end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a), d);
      if (d !== 8'h20) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_fill: %0d addresses not 20, required 0", bad);
    end
  endtask

  task automatic test_stream;
    logic [7:0] d0, d1, d16;
    send_ch(8'h41); send_ch(8'h42); send_ch(CH_LF); send_ch(8'h43);
    rd(6'd0, d0); rd(6'd1, d1); rd(6'd16, d16);
    checks++;
    if (d0 !== 8'h41 || d1 !== 8'h42 || d16 !== 8'h43) begin
      errors++;
      $display("FAIL stream_data: ram0=%h ram1=%h ram16=%h required 41 42 43", d0, d1, d16);
    end
    checks++;
    if (cursor !== 6'd17) begin
      errors++;
      $display("FAIL stream_cursor: cursor=%0d required 17", cursor);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    for (int i = 0; i < 46; i++) send_ch(8'h61);
    #1;
    checks++;
    if (cursor !== 6'd63) begin
      errors++;
      $display("FAIL wrap_pre: cursor=%0d required 63", cursor);
    end
    send_ch(8'h5A);
    rd(6'd63, d);
    checks++;
    if (d !== 8'h5A || cursor !== 6'd0) begin
      errors++;
      $display("FAIL wrap_char: ram63=%h cursor=%0d required 5a 0", d, cursor);
    end
    send_ch(CH_LF); send_ch(CH_LF); send_ch(CH_LF);
    #1;
    checks++;
    if (cursor !== 6'd48) begin
      errors++;
      $display("FAIL lf_line3: cursor=%0d required 48", cursor);
    end
    send_ch(CH_LF);
    #1;
    checks++;
    if (cursor !== 6'd0) begin
      errors++;
      $display("FAIL lf_wrap: cursor=%0d required 0", cursor);
    end
  endtask

  task automatic test_controls;
    logic [7:0] d;
    send_ch(CH_BS);
    #1;
    checks++;
    if (cursor !== 6'd0) begin
      errors++;
      $display("FAIL bs_sat: cursor=%0d required 0", cursor);
    end
    send_ch(8'h78); send_ch(8'h79); send_ch(CH_BS);
    #1;
    checks++;
    if (cursor !== 6'd1) begin
      errors++;
      $display("FAIL bs: cursor=%0d required 1", cursor);
    end
    send_ch(8'h01);
    rd(6'd1, d);
    checks++;
    if (cursor !== 6'd1 || d !== 8'h79) begin
      errors++;
      $display("FAIL ignore_ctl: cursor=%0d ram1=%h required 1 79", cursor, d);
    end
    send_ch(8'h6B); send_ch(CH_LF); send_ch(8'h6C); send_ch(CH_CR);
    #1;
    checks++;
    if (cursor !== 6'd16) begin
      errors++;
      $display("FAIL cr: cursor=%0d required 16", cursor);
    end
    send_ch(CH_LF); send_ch(CH_LF); send_ch(CH_LF);
  endtask

  task automatic test_priority;
    logic [7:0] d5, d0;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h31;
    ch_valid = 1'b1; ch_data = 8'h51;
    #1;
    checks++;
    if (ch_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_stall: ch_ready=%b required 0", ch_ready);
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    checks++;
    if (ch_ready !== 1'b1 || cursor !== 6'd0) begin
      errors++;
      $display("FAIL prio_next: ch_ready=%b cursor=%0d required 1 0", ch_ready, cursor);
    end
    @(posedge clk);
    #1 ch_valid = 1'b0;
    rd(6'd5, d5); rd(6'd0, d0);
    checks++;
    if (d5 !== 8'h31 || d0 !== 8'h51 || cursor !== 6'd1) begin
      errors++;
      $display("FAIL prio_data: ram5=%h ram0=%h cursor=%0d required 31 51 1", d5, d0, cursor);
    end
  endtask

  task automatic test_trigger;
    int t;
    int ntrg;
    logic [7:0] d;
    repeat (2 * M) @(negedge clk);
    checks++;
    if (dirty !== 1'b0 || trg !== 1'b0) begin
      errors++;
      $display("FAIL trig_quiet: dirty=%b trg=%b required 0 0", dirty, trg);
    end
    lcd_busy = 1'b1;
    do_write(6'd40, 8'h61); do_write(6'd41, 8'h62); do_write(6'd42, 8'h63);
    ntrg = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (trg) ntrg++;
    end
    checks++;
    if (ntrg != 0 || dirty !== 1'b1) begin
      errors++;
      $display("FAIL busy_hold: trg_count=%0d dirty=%b required 0 1", ntrg, dirty);
    end
    lcd_busy = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!trg && t < 10);
    checks++;
    if (trg !== 1'b1 || t != 1) begin
      errors++;
      $display("FAIL coalesce_trg: trg=%b after %0d cycles required 1 after 1", trg, t);
    end
    // second trg: write 10 cycles later, fire exactly M after the first
    t = 0;
    do begin
      @(negedge clk); t++;
      if (t == 10) begin wr_en = 1'b1; wr_addr = 6'd43; wr_data = 8'h64; end
      if (t == 11) wr_en = 1'b0;
    end while (!trg && t < 3 * M);
    checks++;
    if (trg !== 1'b1 || t != M) begin
      errors++;
      $display("FAIL holdoff_gap: trg=%b gap=%0d required 1 gap %0d", trg, t, M);
    end
    // write coincident with trg keeps dirty set
    t = 0;
    do begin
      @(negedge clk); t++;
      wr_en = 1'b0;
      if (t == 5)     begin wr_en = 1'b1; wr_addr = 6'd44; wr_data = 8'h65; end
      if (t == M - 1) begin wr_en = 1'b1; wr_addr = 6'd45; wr_data = 8'h66; end
    end while (!trg && t < 3 * M);
    wr_en = 1'b0;
    checks++;
    if (trg !== 1'b1 || t != M || dirty !== 1'b1) begin
      errors++;
      $display("FAIL trg_write_same: trg=%b gap=%0d dirty=%b required 1 %0d 1", trg, t, dirty, M);
    end
    rd(6'd45, d);
    checks++;
    if (d !== 8'h66) begin
      errors++;
      $display("FAIL trg_write_data: ram45=%h required 66", d);
    end
  endtask

  task automatic test_reset_mid_clear;
    logic [7:0] d;
    int bad;
    repeat (2 * M) @(negedge clk);
    send_ch(8'h4D); send_ch(8'h4E);
    rd(6'd63, d);
    checks++;
    if (cursor !== 6'd3 || d !== 8'h5A) begin
      errors++;
      $display("FAIL pre_ff: cursor=%0d rd=%h required 3 5a", cursor, d);
    end
    send_ch(CH_FF);
    repeat (30) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ch_ready, trg, cursor, dirty, rd_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b trg=%b cur=%0d dirty=%b rd=%h required all 0",
               ch_ready, trg, cursor, dirty, rd_data);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      if (ch_ready !== 1'b0) bad++;
    end
    @(negedge clk);
    checks++;
    if (bad != 0 || ch_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_len: early_ready=%0d ready=%b required 0 1", bad, ch_ready);
    end
    rd(6'd63, d);
    checks++;
    if (d !== 8'h20) begin
      errors++;
      $display("FAIL restart_fill: ram63=%h required 20", d);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_wrap;
    test_controls;
    test_priority;
    test_trigger;
    test_reset_mid_clear;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
